tdm_demux_1x4: RTL



---
 rtl/tdm_demux_1x4.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tdm_demux_1x4.sv
// Receive side of a 4:1 TDM serial link: locks onto frame_sync, deserialises four channels.
// Optional error counter (err_cnt/err_clr) enabled by defining TDM_DEMUX_ERR_CNT_EN.
module tdm_demux_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
`ifdef TDM_DEMUX_ERR_CNT_EN
  input  logic                 err_clr,
  output logic [7:0]           err_cnt,
`endif
  output logic [4*WIDTH-1:0]   dout,
  output logic                 out_valid,
  output logic                 locked,
  output logic [1:0]           slot,
  output logic                 sync_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(WIDTH - 1);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic [1:0]                  slot_reg;
  logic [1:0]                  slot_next;
  logic [CW-1:0]               frame_reg;
  logic [CW-1:0]               frame_next;
  logic [3:0][WIDTH-1:0]       ch_reg;
  logic [3:0][WIDTH-1:0]       ch_next;
  logic [4*WIDTH-1:0]          dout_reg;
  logic                        out_valid_reg;
  logic                        sync_err_reg;

  // Beat classification; exactly one of hunt_start/early/missing/shift can fire per beat
  logic hunt_start;
  logic run_beat;
  logic missing;
  logic early;
  logic shift;
  logic restart;
  logic complete;

  always_comb begin
    hunt_start = din_valid && (state_reg == HUNT) && frame_sync;
    run_beat   = din_valid && (state_reg == RUN);
    missing    = run_beat && (slot_reg == 2'd0) && !frame_sync;
    early      = run_beat && (slot_reg != 2'd0) && frame_sync;
    shift      = run_beat && !missing && !early;
    restart    = hunt_start || early;
    complete   = shift && (slot_reg == 2'd3) && (frame_reg == LAST_FRAME);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT: if (hunt_start) state_next = RUN;
      RUN:  if (missing)    state_next = HUNT;
      default:              state_next = HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    locked    = (state_reg == RUN);
    slot      = slot_reg;
    dout      = dout_reg;
    out_valid = out_valid_reg;
    sync_err  = sync_err_reg;
  end

  // A restart seeds ch0 with the sync beat and discards everything else
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    assign ch_next[gi] = restart ? {{(WIDTH-1){1'b0}}, din & (gi == 0)}
                       : missing ? '0
                       : (shift && (slot_reg == 2'(gi))) ? {ch_reg[gi][WIDTH-2:0], din}
                       : ch_reg[gi];
  end

  always_comb begin
    slot_next  = slot_reg;
    frame_next = frame_reg;
    if (restart || missing) begin
      frame_next = '0;
      slot_next  = restart ? 2'd1 : 2'd0;
    end else if (shift) begin
      slot_next = slot_reg + 2'd1;
      if (slot_reg == 2'd3) begin
        frame_next = complete ? '0 : frame_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg      <= 2'd0;
      frame_reg     <= '0;
      ch_reg        <= '0;
      dout_reg      <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      slot_reg      <= slot_next;
      frame_reg     <= frame_next;
      ch_reg        <= ch_next;
      out_valid_reg <= complete;
      sync_err_reg  <= missing || early;
      // ch_next already holds the final bit of channel 3
      if (complete) begin
        dout_reg <= ch_next;
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (err_clr) begin
      err_cnt_reg <= 8'd0;
    end else if ((missing || early) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule
